// File: rtl/ones_count_pkg.sv
// Shared definitions for the sequential ones counter: ceil-log2 helper and FSM state encoding.
package ones_count_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ones_chunk.sv
// Combinational popcount of one W-bit chunk.
module ones_chunk
    import ones_count_pkg::*;
#(
    parameter  int W     = 4,
    localparam int OUT_W = clog2(W + 1)
) (
    input  logic [W-1:0]     chunk_i,
    output logic [OUT_W-1:0] ones_o
);

    always_comb begin
        ones_o = '0;
        for (int i = 0; i < W; i++) begin
            ones_o = ones_o + OUT_W'(chunk_i[i]);
        end
    end

endmodule

// File: rtl/seq_ones_count.sv
// Multi-cycle popcount: counts CHUNK_W bits per cycle and keeps a saturating running total.
//
// state  | meaning
// S_IDLE | waiting for start; dat_in/acc_en captured on start
// S_RUN  | one chunk counted per cycle, N cycles
// S_DONE | result published, done pulse, back to idle
module seq_ones_count
    import ones_count_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int CHUNK_W = 4,
    parameter  int TOT_W   = 16,
    localparam int CNT_W   = clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dat_in,
    input  logic              acc_en,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic [TOT_W-1:0]  total
);

    localparam int N     = DATA_W / CHUNK_W;
    localparam int IDX_W = (N > 1) ? clog2(N) : 1;
    localparam int PC_W  = clog2(CHUNK_W + 1);
    localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [SUM_W-1:0] TOT_MAX  = (SUM_W'(1) << TOT_W) - SUM_W'(1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  part_q, part_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TOT_W-1:0]  total_q, total_d;

    logic [PC_W-1:0]   chunk_ones;
    logic [CNT_W-1:0]  part_fin;
    logic [SUM_W-1:0]  sum_base;
    logic [SUM_W-1:0]  sum_full;
    logic [TOT_W-1:0]  tot_sat;

    ones_chunk #(.W(CHUNK_W)) u_chunk (
        .chunk_i (shift_q[CHUNK_W-1:0]),
        .ones_o  (chunk_ones)
    );

    // A clear landing on the completion edge must not be overwritten by the old total.
    always_comb begin
        part_fin = part_q + CNT_W'(chunk_ones);
        sum_base = (acc_q && !clr) ? SUM_W'(total_q) : '0;
        sum_full = sum_base + SUM_W'(part_fin);
        tot_sat  = (sum_full > TOT_MAX) ? {TOT_W{1'b1}} : sum_full[TOT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        part_d  = part_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        count_d = count_q;
        total_d = clr ? '0 : total_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = dat_in;
                    acc_d   = acc_en;
                    part_d  = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                part_d  = part_fin;
                shift_d = shift_q >> CHUNK_W;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    count_d = part_fin;
                    total_d = tot_sat;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            part_q  <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            part_q  <= part_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            total_q <= total_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    assign total = total_q;

endmodule
